// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl: sequencer for an 8-bit parallel-load / serial-out shift register.
// It accepts words over valid/ready, issues a one-cycle active-low parallel load and
// paces one shift enable every DIV clocks, MSB first. It mirrors the serial bit and
// reports busy/done.
// Optional feature: define PARITY_EN to append an even-parity bit slot after the data
// bits. Without the macro, no parity state or parity logic exists.
module piso_shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4,
    parameter int GAP   = 1
) (
    input  logic             cp,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] p_out,
    output logic             pl_n,
    output logic             sh_en,
    output logic             ds,
    output logic             ser_bit,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
`ifdef PARITY_EN
        S_PAR   = 3'd3,
`endif
        S_GAP   = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    state_t           post_state;
    logic [DW-1:0]    div_cnt;
    logic [DW-1:0]    div_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_nxt;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_nxt;
    logic [BW-1:0]    idx;
    logic [WIDTH-1:0] hold;
    logic             in_ready_q;
    logic             pl_n_q;
    logic             sh_en_q;
    logic             done_q;
    logic             busy_q;
    logic             ser_bit_q;
    logic [WIDTH-1:0] p_out_q;
    logic             sh_nxt;
    logic             done_nxt;
    logic             busy_nxt;
    logic             ser_nxt;
    logic             div_last;
    logic             bit_last;

    // A frame that ends (normally or by abort) skips the gap state when GAP is zero.
    assign post_state = (GAP == 0) ? S_IDLE : S_GAP;
    assign div_last   = (div_cnt == DW'(DIV - 1));
    assign bit_last   = (bit_cnt == BW'(WIDTH - 1));

    // Next state and counter values. Registered outputs are derived from these, so each
    // output lines up with the cycle its state applies to.
    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready_q) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_SHIFT;
                div_nxt   = '0;
                bit_nxt   = '0;
            end
            S_SHIFT: begin
                if (abort) begin
                    state_nxt = post_state;
                    gap_nxt   = '0;
                end else if (div_last) begin
                    div_nxt = '0;
                    if (bit_last) begin
`ifdef PARITY_EN
                        state_nxt = S_PAR;
`else
                        state_nxt = post_state;
                        gap_nxt   = '0;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                if (abort || div_last) begin
                    state_nxt = post_state;
                    gap_nxt   = '0;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
`endif
            S_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) state_nxt = S_IDLE;
                else gap_nxt = gap_cnt + 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, computed from the next state and counters.
    always_comb begin
        sh_nxt   = 1'b0;
        done_nxt = 1'b0;
        busy_nxt = 1'b0;
        ser_nxt  = 1'b0;
        idx      = BW'(WIDTH - 1) - bit_nxt;
        case (state_nxt)
            S_LOAD: begin
                busy_nxt = 1'b1;
                ser_nxt  = in_data[WIDTH-1];
            end
            S_SHIFT: begin
                busy_nxt = 1'b1;
                ser_nxt  = hold[idx];
                if (div_nxt == DW'(DIV - 1)) begin
                    sh_nxt = 1'b1;
`ifndef PARITY_EN
                    done_nxt = (bit_nxt == BW'(WIDTH - 1));
`endif
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                busy_nxt = 1'b1;
                ser_nxt  = ^hold;
                if (div_nxt == DW'(DIV - 1)) begin
                    sh_nxt   = 1'b1;
                    done_nxt = 1'b1;
                end
            end
`endif
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Single FSM register: state, counters, captured word and all registered outputs.
    always_ff @(posedge cp) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            hold       <= '0;
            p_out_q    <= '0;
            in_ready_q <= 1'b0;
            pl_n_q     <= 1'b1;
            sh_en_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ser_bit_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            gap_cnt <= gap_nxt;
            if (state == S_IDLE && state_nxt == S_LOAD) begin
                hold    <= in_data;
                p_out_q <= in_data;
            end
            in_ready_q <= (state_nxt == S_IDLE);
            pl_n_q     <= (state_nxt != S_LOAD);
            sh_en_q    <= sh_nxt;
            done_q     <= done_nxt;
            busy_q     <= busy_nxt;
            ser_bit_q  <= ser_nxt;
        end
    end

    // An abort in the current cycle suppresses any shift or completion pulse scheduled for it.
    assign sh_en    = sh_en_q & ~abort;
    assign done     = done_q & ~abort;
    assign in_ready = in_ready_q;
    assign pl_n     = pl_n_q;
    assign busy     = busy_q;
    assign ser_bit  = ser_bit_q;
    assign p_out    = p_out_q;
    assign ds       = 1'b0;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Scoreboard bench for piso_shift_ctrl (WIDTH=8, DIV=4, GAP=1); honours PARITY_EN.
module tb_piso_shift_ctrl;
    localparam int WIDTH = 8;
    localparam int DIV   = 4;
    localparam int GAP   = 1;
`ifdef PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int FRAME = NBITS * DIV;

    logic             cp;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             abort;
    logic [WIDTH-1:0] p_out;
    logic             pl_n;
    logic             sh_en;
    logic             ds;
    logic             ser_bit;
    logic             busy;
    logic             done;

    piso_shift_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .GAP(GAP)) dut (
        .cp(cp), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort), .p_out(p_out), .pl_n(pl_n),
        .sh_en(sh_en), .ds(ds), .ser_bit(ser_bit), .busy(busy), .done(done)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    int cyc = 0;
    always @(posedge cp) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] wq[$];
    bit               bq[$];
    int               aq[$];
    int               dq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents a load, shift or done.
    int  lc = 0;
    int  k = 0;
    int  last_done = 0;
    bit  chk_rdy = 0;
    logic rdy_prev = 1'b0;
    always @(negedge cp) begin
        if (pl_n === 1'b0) begin
            lc = cyc;
            k  = 0;
            check("pl_sh_exclusive", {31'd0, sh_en}, 32'd0);
            check("busy_in_load", {31'd0, busy}, 32'd1);
            if (aq.size() == 0) fail_evt("unexpected_load");
            else check("load_latency", cyc, aq.pop_front());
            if (wq.size() == 0) fail_evt("unexpected_word");
            else begin
                logic [WIDTH-1:0] w;
                w = wq.pop_front();
                check("p_out", {24'd0, p_out}, {24'd0, w});
                check("ser_bit_load", {31'd0, ser_bit}, {31'd0, w[WIDTH-1]});
            end
        end
        if (sh_en === 1'b1) begin
            k++;
            check("sh_en_time", cyc, lc + k * DIV);
            if (bq.size() == 0) fail_evt("unexpected_sh_en");
            else check("ser_bit", {31'd0, ser_bit}, {31'd0, bq.pop_front()});
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) fail_evt("unexpected_done");
            else begin
                void'(dq.pop_front());
                check("done_time", cyc, lc + FRAME);
                check("done_shift_count", k, NBITS);
                last_done = cyc;
                chk_rdy   = 1;
            end
        end
        if (in_ready === 1'b1 && rdy_prev !== 1'b1 && chk_rdy) begin
            check("in_ready_return", cyc, last_done + 1 + GAP);
            chk_rdy = 0;
        end
        rdy_prev = in_ready;
    end

    // Queue the expected word, the first nb serial bits (data MSB first, then parity) and
    // a done expectation for frames that run to completion.
    task automatic push_frame(input logic [WIDTH-1:0] w, input int nb, input bit full, input bit par);
        wq.push_back(w);
        for (int i = 0; i < nb; i++) begin
            if (i < WIDTH) bq.push_back(w[WIDTH-1-i]);
            else bq.push_back(par);
        end
        if (full) dq.push_back(1);
    endtask

    // Called at a negedge; holds in_valid until the word is taken, returns just after the accepting edge.
    task automatic offer(input logic [WIDTH-1:0] w, output int acc);
        in_data  = w;
        in_valid = 1'b1;
        acc      = -1;
        for (int t = 0; t < 200; t++) begin
            if (in_ready === 1'b1) begin
                acc = cyc + 1;
                aq.push_back(acc);
                @(posedge cp);
                return;
            end
            @(negedge cp);
        end
        fail_evt("accept_timeout");
    endtask

    task automatic wait_idle();
        for (int t = 0; t < FRAME + 60; t++) begin
            @(negedge cp);
            if (in_ready === 1'b1 && dq.size() == 0 && bq.size() == 0) return;
        end
        fail_evt("frame_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_pl_n"},     {31'd0, pl_n},     32'd1);
        check({tag, "_sh_en"},    {31'd0, sh_en},    32'd0);
        check({tag, "_ser_bit"},  {31'd0, ser_bit},  32'd0);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_p_out"},    {24'd0, p_out},    32'd0);
        check({tag, "_ds"},       {31'd0, ds},       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int a1, a2, a;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        abort    = 1'b0;
        repeat (3) @(negedge cp);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge cp);

        // Idle after reset release: ready, no load, no shift, not busy.
        for (int i = 0; i < 20; i++) begin
            check("idle_after_reset", {28'd0, in_ready, pl_n, sh_en, busy}, 32'b1100);
            @(negedge cp);
        end

        // Abort while idle is ignored.
        abort = 1'b1;
        @(negedge cp);
        abort = 1'b0;
        check("abort_in_idle_ready", {31'd0, in_ready}, 32'd1);

        // Single word 0xA5: stream 1,0,1,0,0,1,0,1 (parity 0).
        push_frame(8'hA5, NBITS, 1, 1'b0);
        offer(8'hA5, a1);
        @(negedge cp);
        in_valid = 1'b0;
        wait_idle();

        // Back-to-back 0x3C then 0xFF with in_valid held.
        push_frame(8'h3C, NBITS, 1, 1'b0);
        push_frame(8'hFF, NBITS, 1, 1'b0);
        offer(8'h3C, a1);
        @(negedge cp);
        offer(8'hFF, a2);
        check("b2b_accept_spacing", a2 - a1, FRAME + GAP + 2);
        @(negedge cp);
        in_valid = 1'b0;
        wait_idle();

        // Reset at L+10: only the shifts at L+4 and L+8 occur.
        push_frame(8'hA5, 2, 0, 1'b0);
        offer(8'hA5, a);
        @(negedge cp);
        in_valid = 1'b0;
        repeat (10) @(negedge cp);
        rst_n = 1'b0;
        @(negedge cp);
        check_reset_outputs("midrst");
        check("midrst_bits_consumed", bq.size(), 0);
        rst_n = 1'b1;
        @(negedge cp);
        check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
        push_frame(8'hC3, NBITS, 1, 1'b0);
        offer(8'hC3, a);
        @(negedge cp);
        in_valid = 1'b0;
        wait_idle();

        // Abort at L+13: three shifts (1,0,0 of 0x96), no done, ready one gap later.
        push_frame(8'h96, 3, 0, 1'b0);
        offer(8'h96, a);
        @(negedge cp);
        in_valid = 1'b0;
        repeat (13) @(negedge cp);
        abort = 1'b1;
        @(negedge cp);
        abort = 1'b0;
        check("abort_gap_ready", {30'd0, in_ready, busy}, 32'b00);
        repeat (GAP) @(negedge cp);
        check("abort_ready_back", {31'd0, in_ready}, 32'd1);
        repeat (FRAME + 8) @(negedge cp);

        // 0x07: parity bit 1 when enabled.
        push_frame(8'h07, NBITS, 1, 1'b1);
        offer(8'h07, a);
        @(negedge cp);
        in_valid = 1'b0;
        wait_idle();

        repeat (10) @(negedge cp);
        check("end_bits_left", bq.size(), 0);
        check("end_dones_left", dq.size(), 0);
        check("end_words_left", wq.size(), 0);
        check("end_accepts_left", aq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
